fpu_result_buffer: RTL and testbench
====================================

Name: fpu_result_buffer

Overview:
- Writeback-side result buffer directly downstream of the FPU functional units, including the classify unit, which produces a 32-bit mask destined for an integer rd.
- Accepts one result per cycle over a valid/ready handshake and stores it in a small first-word-fall-through FIFO.
- Presents entries in order to the register-file writeback port.
- Accumulates the sticky fflags of every retired result.

Parameters:
- DATA_W, 32, result width in bits.
- DEPTH, 2, FIFO entries; power of two, at least 2.
- RD_W, 5, destination register index width.

Ports:
- wb_clk_i  input  1  clock; all logic is rising-edge.
- wb_rst_i  input  1  synchronous reset, active-high.
- in_valid  input  1  producer has a result.
- in_ready  output  1  buffer can accept; equals !full.
- in_result  input  DATA_W  result data; for classify, the zero-extended 10-bit class mask.
- in_rd  input  RD_W  destination register.
- in_int_dest  input  1  1 = integer regfile, 0 = FP regfile.
- in_flags  input  5  fflags {NV,DZ,OF,UF,NX}.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  writeback consumes the head.
- out_result  output  DATA_W  head result.
- out_rd  output  RD_W  head rd.
- out_int_dest  output  1  head destination type.
- out_flags  output  5  head flags.
- fflags_acc  output  5  sticky OR of retired flags.
- fflags_clr  input  1  clear fflags_acc (CSR write).
- count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (wb_rst_i=1 at a clock edge):
  - wr_ptr, rd_ptr, count and fflags_acc go to 0.
  - out_valid=0 and in_ready=1.
  - Storage contents are don't-care, but out_result/out_rd/out_int_dest/out_flags are driven 0 while out_valid=0.
  - Reset mid-traffic discards all entries; no handshake completes in the reset cycle.
- Push: in_valid & in_ready. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH (wraps to 0).
- Pop: out_valid & out_ready. rd_ptr increments modulo DEPTH.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: unchanged.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1.
  - No combinational in->out bypass, even when empty.
  - No path from out_ready to in_ready.
- Full (count==DEPTH):
  - in_ready=0, even if out_ready=1 in that cycle.
  - in_valid is ignored; the producer must hold its data.
- Empty (count==0): out_valid=0; out_ready is ignored.
- out_* reflect the head entry combinationally from storage and stay stable while out_valid & !out_ready.
- fflags_acc, next value, by case:
  - fflags_clr=1 and pop: out_flags (clear first, then accumulate).
  - fflags_clr=1, no pop: 0.
  - fflags_clr=0 and pop: fflags_acc | out_flags.
  - otherwise: held.
- Ordering is strictly FIFO; entries are never reordered or merged.

Optional Feature:
- Macro: FPU_RESULT_BUF_X0_DROP_EN.
- Defined:
  - An accepted entry with in_int_dest=1 and in_rd=0 (write to x0) is not stored; wr_ptr and count are unchanged.
  - in_ready still follows !full; the drop happens at the handshake.
  - Its in_flags are ORed into fflags_acc in the accept cycle.
  - In the same cycle this OR combines with any pop flags and follows the same clr precedence: with clr=1 the next value is pop flags | dropped flags.
- Undefined: x0 writes are buffered and retired like any other entry. in_int_dest=0 with rd=0 (FP f0) is always buffered.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, count=0, fflags_acc=0, all out_* = 0.
- Push result 0x00000200 (quiet-NaN class bit), rd=7, int_dest=1, flags=0 at cycle N with out_ready=1 -> out_valid=1 in N+1 with 0x200/7/1; popped; count returns to 0 in N+2.
- out_ready=0, push 3 entries (DEPTH=2) -> first two accepted; in_ready=0 with count=2; third held. Release out_ready -> entries emerge in order; third accepted only after in_ready rises; pointers wrap cleanly over 6 pushes/pops.
- Pop entries with flags 5'b00001 then 5'b10000 -> fflags_acc=5'b10001. Assert fflags_clr in the same cycle as popping flags 5'b00100 -> fflags_acc=5'b00100.
- Full buffer, in_valid=1, out_ready=1 -> one pop, no push that cycle, count=1; the push is accepted next cycle.
- With FPU_RESULT_BUF_X0_DROP_EN: push int_dest=1, rd=0, flags=5'b10000 -> count stays 0, out_valid=0, fflags_acc=5'b10000. Without the macro -> the entry appears on out_* next cycle.

Source files
------------

// File: rtl/fpu_result_buffer_if.sv
// Handshake bundle between FPU result producers, the result buffer and regfile writeback.
// The buffer takes the slave modport; the producer/writeback side takes master.
interface fpu_result_buffer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int RD_W   = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [RD_W-1:0]   in_rd;
  logic              in_int_dest;
  logic [4:0]        in_flags;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [RD_W-1:0]   out_rd;
  logic              out_int_dest;
  logic [4:0]        out_flags;
  logic [4:0]        fflags_acc;
  logic              fflags_clr;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_result, in_rd, in_int_dest, in_flags, out_ready, fflags_clr,
    input  in_ready, out_valid, out_result, out_rd, out_int_dest, out_flags, fflags_acc, count
  );

  modport slave (
    input  in_valid, in_result, in_rd, in_int_dest, in_flags, out_ready, fflags_clr,
    output in_ready, out_valid, out_result, out_rd, out_int_dest, out_flags, fflags_acc, count
  );
endinterface

// File: rtl/fpu_result_buffer.sv
// FPU writeback result FIFO (first-word-fall-through) with sticky fflags accumulation.
// Optional macro FPU_RESULT_BUF_X0_DROP_EN: integer writes to x0 are absorbed at the handshake.
module fpu_result_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int RD_W   = 5
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  fpu_result_buffer_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] res_mem_q  [DEPTH];
  logic [RD_W-1:0]   rd_mem_q   [DEPTH];
  logic              int_mem_q  [DEPTH];
  logic [4:0]        flg_mem_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       fflags_acc_q, fflags_acc_d;

  logic push_s, pop_s, store_s, drop_s, full_s, empty_s;
  logic [4:0] add_flags_s;

  // Handshake decode, next-state and head presentation.
  always_comb begin
    full_s   = (count_q == CNT_W'(DEPTH));
    empty_s  = (count_q == {CNT_W{1'b0}});
    // Handshakes never complete while reset is asserted.
    push_s   = bus.in_valid & ~full_s & ~wb_rst_i;
    pop_s    = bus.out_ready & ~empty_s & ~wb_rst_i;
`ifdef FPU_RESULT_BUF_X0_DROP_EN
    drop_s   = push_s & bus.in_int_dest & (bus.in_rd == {RD_W{1'b0}});
`else
    drop_s   = 1'b0;
`endif
    store_s  = push_s & ~drop_s;

    bus.in_ready  = ~full_s;
    bus.out_valid = ~empty_s;
    if (!empty_s) begin
      bus.out_result   = res_mem_q[rd_ptr_q];
      bus.out_rd       = rd_mem_q[rd_ptr_q];
      bus.out_int_dest = int_mem_q[rd_ptr_q];
      bus.out_flags    = flg_mem_q[rd_ptr_q];
    end else begin
      bus.out_result   = {DATA_W{1'b0}};
      bus.out_rd       = {RD_W{1'b0}};
      bus.out_int_dest = 1'b0;
      bus.out_flags    = 5'b00000;
    end
    bus.fflags_acc = fflags_acc_q;
    bus.count      = count_q;

    wr_ptr_d = store_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    case ({store_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Clear takes effect before this cycle's retired/dropped flags are merged.
    add_flags_s = (pop_s ? bus.out_flags : 5'b00000) | (drop_s ? bus.in_flags : 5'b00000);
    if (bus.fflags_clr) begin
      fflags_acc_d = add_flags_s;
    end else begin
      fflags_acc_d = fflags_acc_q | add_flags_s;
    end
  end

  // Control state registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      fflags_acc_q <= 5'b00000;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fflags_acc_q <= fflags_acc_d;
    end
  end

  // Entry storage; contents are irrelevant while unoccupied so no reset.
  always_ff @(posedge wb_clk_i) begin
    if (store_s) begin
      res_mem_q[wr_ptr_q] <= bus.in_result;
      rd_mem_q[wr_ptr_q]  <= bus.in_rd;
      int_mem_q[wr_ptr_q] <= bus.in_int_dest;
      flg_mem_q[wr_ptr_q] <= bus.in_flags;
    end
  end
endmodule

// File: tb/tb_fpu_result_buffer.sv
// Self-checking bench for fpu_result_buffer: directed test-plan steps then random traffic
// against a queue-based reference model.
module tb_fpu_result_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int RD_W   = 5;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
`ifdef FPU_RESULT_BUF_X0_DROP_EN
  localparam bit X0DROP = 1'b1;
`else
  localparam bit X0DROP = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] res;
    logic [RD_W-1:0]   rd;
    logic              idst;
    logic [4:0]        fl;
  } ent_t;

  logic wb_clk_i;
  logic wb_rst_i;
  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  logic [4:0] m_acc;

  fpu_result_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_W(RD_W)) bus ();

  fpu_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    ent_t h;
    h = '{res: '0, rd: '0, idst: 1'b0, fl: 5'b0};
    if (q.size() > 0) h = q[0];
    chk({tag, ".count"},     64'(bus.count), 64'(q.size()));
    chk({tag, ".in_ready"},  64'(bus.in_ready), 64'(q.size() < DEPTH));
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() > 0));
    chk({tag, ".result"},    64'(bus.out_result), 64'(h.res));
    chk({tag, ".rd"},        64'(bus.out_rd), 64'(h.rd));
    chk({tag, ".int_dest"},  64'(bus.out_int_dest), 64'(h.idst));
    chk({tag, ".flags"},     64'(bus.out_flags), 64'(h.fl));
    chk({tag, ".acc"},       64'(bus.fflags_acc), 64'(m_acc));
  endtask

  // One clock with the given inputs; model predicts from the pre-edge state.
  task automatic step(input string tag, input logic v, input logic [DATA_W-1:0] res,
                      input logic [RD_W-1:0] rd, input logic idst, input logic [4:0] fl,
                      input logic rdy, input logic clr);
    bit   m_push, m_pop, m_drop;
    logic [4:0] add;
    ent_t e;
    bus.in_valid = v; bus.in_result = res; bus.in_rd = rd; bus.in_int_dest = idst;
    bus.in_flags = fl; bus.out_ready = rdy; bus.fflags_clr = clr;
    m_push = v && (q.size() < DEPTH);
    m_pop  = rdy && (q.size() > 0);
    m_drop = m_push && X0DROP && idst && (rd == '0);
    add    = m_pop ? q[0].fl : 5'b0;
    if (m_drop) add = add | fl;
    e = '{res: res, rd: rd, idst: idst, fl: fl};
    @(posedge wb_clk_i);
    #1;
    m_acc = clr ? add : (m_acc | add);
    if (m_pop) void'(q.pop_front());
    if (m_push && !m_drop) q.push_back(e);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    wb_rst_i = 1'b1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.fflags_clr = 1'b0;
    bus.in_result = 32'hDEAD_BEEF; bus.in_rd = 5'd3; bus.in_int_dest = 1'b0; bus.in_flags = 5'b11111;
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    q.delete();
    m_acc = 5'b0;
    check_all(tag);
  endtask

  initial begin
    wb_rst_i = 1'b1;
    bus.in_valid = 1'b0; bus.in_result = '0; bus.in_rd = '0; bus.in_int_dest = 1'b0;
    bus.in_flags = 5'b0; bus.out_ready = 1'b0; bus.fflags_clr = 1'b0;
    m_acc = 5'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    do_reset("reset");
    step("idle", 1'b0, 32'h0, 5'd0, 1'b0, 5'b0, 1'b0, 1'b0);

    // Classify mask through the buffer with one-cycle latency.
    step("cls_push", 1'b1, 32'h0000_0200, 5'd7, 1'b1, 5'b0, 1'b1, 1'b0);
    chk("cls_result", 64'(bus.out_result), 64'h200);
    step("cls_pop", 1'b0, 32'h0, 5'd0, 1'b0, 5'b0, 1'b1, 1'b0);

    // Fill with consumer stalled, then drain; third entry held by producer.
    step("fill0", 1'b1, 32'h1111_0001, 5'd1, 1'b0, 5'b0, 1'b0, 1'b0);
    step("fill1", 1'b1, 32'h1111_0002, 5'd2, 1'b1, 5'b0, 1'b0, 1'b0);
    step("fill2", 1'b1, 32'h1111_0003, 5'd3, 1'b0, 5'b0, 1'b0, 1'b0);
    step("stall", 1'b1, 32'h1111_0003, 5'd3, 1'b0, 5'b0, 1'b0, 1'b0);
    step("full_pop", 1'b1, 32'h1111_0003, 5'd3, 1'b0, 5'b0, 1'b1, 1'b0);
    chk("full_pop_count", 64'(bus.count), 64'd1);
    for (int i = 0; i < 6; i++)
      step("wrap", 1'b1, 32'h2222_0000 + 32'(i), 5'(i + 8), 1'(i), 5'b0, 1'b1, 1'b0);
    step("drain0", 1'b0, 32'h0, 5'd0, 1'b0, 5'b0, 1'b1, 1'b0);
    step("drain1", 1'b0, 32'h0, 5'd0, 1'b0, 5'b0, 1'b1, 1'b0);

    // Sticky flag accumulation and clear-then-accumulate.
    step("fl_push0", 1'b1, 32'h3, 5'd4, 1'b0, 5'b00001, 1'b0, 1'b0);
    step("fl_push1", 1'b1, 32'h4, 5'd5, 1'b0, 5'b10000, 1'b0, 1'b0);
    step("fl_pop0", 1'b0, 32'h0, 5'd0, 1'b0, 5'b0, 1'b1, 1'b0);
    step("fl_pop1", 1'b0, 32'h0, 5'd0, 1'b0, 5'b0, 1'b1, 1'b0);
    chk("acc_or", 64'(bus.fflags_acc), 64'(5'b10001));
    step("fl_push2", 1'b1, 32'h5, 5'd6, 1'b0, 5'b00100, 1'b0, 1'b0);
    step("fl_clrpop", 1'b0, 32'h0, 5'd0, 1'b0, 5'b0, 1'b1, 1'b1);
    chk("acc_clr_pop", 64'(bus.fflags_acc), 64'(5'b00100));
    step("fl_clr", 1'b0, 32'h0, 5'd0, 1'b0, 5'b0, 1'b0, 1'b1);

    // x0 integer write: dropped or buffered depending on the build; f0 always buffered.
    step("x0_push", 1'b1, 32'hABCD, 5'd0, 1'b1, 5'b10000, 1'b0, 1'b0);
    step("f0_push", 1'b1, 32'hF0F0, 5'd0, 1'b0, 5'b00010, 1'b0, 1'b0);
    step("x0_drain0", 1'b0, 32'h0, 5'd0, 1'b0, 5'b0, 1'b1, 1'b0);
    step("x0_drain1", 1'b0, 32'h0, 5'd0, 1'b0, 5'b0, 1'b1, 1'b0);

    // Reset in the middle of traffic.
    step("pre_rst0", 1'b1, 32'h77, 5'd9, 1'b0, 5'b01000, 1'b0, 1'b0);
    step("pre_rst1", 1'b1, 32'h78, 5'd10, 1'b0, 5'b00000, 1'b0, 1'b0);
    do_reset("mid_reset");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [RD_W-1:0] rrd;
      rrd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step("rand", 1'($urandom_range(0, 2) != 0), $urandom, rrd, 1'($urandom),
           5'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
